input_conditioner: RTL

Parametrised N-channel push-button front end. It supersedes the per-switch debounce instances in the game top level. Each channel has:
- a 2-FF synchroniser
- an optional polarity inversion
- a counter-based debouncer
- registered press and release edge pulses
- a per-channel hold-to-repeat state machine for paddle auto-movement and menu stepping

It sits between board pins and the game or menu logic. All outputs are synchronous to i_Clk.

---
 rtl/input_conditioner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// N-channel push-button front end: synchroniser, polarity fix, debouncer,
// press/release edge pulses and hold-to-repeat, all in the i_Clk domain.
module input_conditioner #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Repeat_En,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Repeat,
  output logic              o_Any_Press
);

  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(DEBOUNCE_LIMIT);
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
  localparam logic             IDLE_LVL   = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_t;

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;

  // Sync flops start at the physical idle level so reset release is silent.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1 <= {NUM_CH{IDLE_LVL}};
      sync2 <= {NUM_CH{IDLE_LVL}};
    end else begin
      sync1 <= i_Switch;
      sync2 <= sync1;
    end
  end

  assign lvl = ACTIVE_LOW ? ~sync2 : sync2;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             sw_q;
    logic             press_q;
    logic             release_q;
    logic             rpt_q;
    logic [TMR_W-1:0] timer;
    rpt_state_t       state;

    // Terminal-count events: the edge on which the debounced level flips.
    assign rise[ch] = lvl[ch] & ~sw_q & (cnt == CNT_LAST);
    assign fall[ch] = ~lvl[ch] & sw_q & (cnt == CNT_LAST);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        cnt       <= '0;
        sw_q      <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= rise[ch];
        release_q <= fall[ch];
        if (lvl[ch] == sw_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          sw_q <= lvl[ch];
          cnt  <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    // A release or a dropped enable takes priority over a coincident terminal count.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        state <= ST_IDLE;
        timer <= '0;
        rpt_q <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        case (state)
          ST_IDLE: begin
            timer <= '0;
            if (rise[ch] && i_Repeat_En[ch]) state <= ST_DELAY;
          end
          ST_DELAY: begin
            if (fall[ch] || !i_Repeat_En[ch]) begin
              state <= ST_IDLE;
              timer <= '0;
            end else if (timer == DELAY_LAST) begin
              rpt_q <= 1'b1;
              timer <= '0;
              state <= ST_REPEAT;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          ST_REPEAT: begin
            if (fall[ch] || !i_Repeat_En[ch]) begin
              state <= ST_IDLE;
              timer <= '0;
            end else if (timer == RATE_LAST) begin
              rpt_q <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            timer <= '0;
          end
        endcase
      end
    end

    assign o_Switch[ch]  = sw_q;
    assign o_Press[ch]   = press_q;
    assign o_Release[ch] = release_q;
    assign o_Repeat[ch]  = rpt_q;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) o_Any_Press <= 1'b0;
    else       o_Any_Press <= |o_Press;
  end

endmodule
